// File: rtl/galaxian_dl_pkg.sv
// Galaxian ROM download controller: shared constants and types.
// Holds the ioctl/ROM bus widths, the region map (base, size, end, offset mask)
// for the CPU, GFX and PROM regions, the one-hot region bit positions, and the
// controller state enum.
package galaxian_dl_pkg;

   localparam int unsigned IOCTL_AW = 25;
   localparam int unsigned ROM_AW   = 14;
   localparam int unsigned COUNT_W  = 16;

   // Region map within the low 15 address bits; everything at or above 0x5020 is dropped.
   localparam logic [14:0] CPU_BASE  = 15'h0000;
   localparam logic [14:0] CPU_SIZE  = 15'h4000;
   localparam logic [14:0] GFX_BASE  = 15'h4000;
   localparam logic [14:0] GFX_SIZE  = 15'h1000;
   localparam logic [14:0] PROM_BASE = 15'h5000;
   localparam logic [14:0] PROM_SIZE = 15'h0020;

   localparam logic [14:0] CPU_END  = CPU_BASE + CPU_SIZE;
   localparam logic [14:0] GFX_END  = GFX_BASE + GFX_SIZE;
   localparam logic [14:0] PROM_END = PROM_BASE + PROM_SIZE;

   // Every base is aligned to its size, so masking the address equals subtracting the base.
   localparam logic [13:0] CPU_MASK  = 14'(CPU_SIZE - 15'd1);
   localparam logic [13:0] GFX_MASK  = 14'(GFX_SIZE - 15'd1);
   localparam logic [13:0] PROM_MASK = 14'(PROM_SIZE - 15'd1);

   // Bit positions in the one-hot region vector.
   localparam int unsigned RGN_CPU  = 0;
   localparam int unsigned RGN_GFX  = 1;
   localparam int unsigned RGN_PROM = 2;

   typedef logic [2:0] region_t;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StSettle,
      StRun,
      StFail
   } state_t;

endpackage

// File: rtl/galaxian_dl_ctrl_if.sv
// Download bus between the HPS ioctl side and the ROM-loading controller.
// ioctl_download/ioctl_wr/ioctl_addr/ioctl_dout : download stream from the HPS.
// rom_addr/rom_data/we_cpu/we_gfx/we_prom       : registered ROM write port.
// core_reset/dl_done/dl_error/byte_count        : load status.
// master drives the ioctl stream; slave is the controller.
interface galaxian_dl_ctrl_if;
   import galaxian_dl_pkg::*;

   logic                  ioctl_download;
   logic                  ioctl_wr;
   logic [IOCTL_AW-1:0]   ioctl_addr;
   logic [7:0]            ioctl_dout;

   logic [ROM_AW-1:0]     rom_addr;
   logic [7:0]            rom_data;
   logic                  we_cpu;
   logic                  we_gfx;
   logic                  we_prom;
   logic                  core_reset;
   logic                  dl_done;
   logic                  dl_error;
   logic [COUNT_W-1:0]    byte_count;

   modport master (
      output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
      input  rom_addr, rom_data, we_cpu, we_gfx, we_prom,
      input  core_reset, dl_done, dl_error, byte_count
   );

   modport slave (
      input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
      output rom_addr, rom_data, we_cpu, we_gfx, we_prom,
      output core_reset, dl_done, dl_error, byte_count
   );

endinterface

// File: rtl/dl_region_decode.sv
// Combinational address decoder for the Galaxian ROM download.
// addr     : ioctl byte address.
// region   : one-hot {prom, gfx, cpu}; all zero when out of range.
// offset   : address minus the selected region base (zero when out of range).
// in_range : address falls in one of the three regions.
module dl_region_decode
   import galaxian_dl_pkg::*;
(
   input  logic [IOCTL_AW-1:0] addr,
   output region_t             region,
   output logic [ROM_AW-1:0]   offset,
   output logic                in_range
);

   logic        hi_zero;
   logic [14:0] lo;

   // Any bit from 15 upward lands beyond the PROM end.
   assign hi_zero = (addr[IOCTL_AW-1:15] == '0);
   assign lo      = addr[14:0];

   always_comb begin
      region = '0;
      // CPU base is zero, so only the upper bound needs checking.
      region[RGN_CPU]  = hi_zero && (lo < CPU_END);
      region[RGN_GFX]  = hi_zero && (lo >= GFX_BASE) && (lo < GFX_END);
      region[RGN_PROM] = hi_zero && (lo >= PROM_BASE) && (lo < PROM_END);
   end

   always_comb begin
      offset = '0;
      if (region[RGN_CPU]) begin
         offset = lo[13:0] & CPU_MASK;
      end else if (region[RGN_GFX]) begin
         offset = lo[13:0] & GFX_MASK;
      end else if (region[RGN_PROM]) begin
         offset = lo[13:0] & PROM_MASK;
      end
   end

   assign in_range = |region;

endmodule

// File: rtl/galaxian_dl_ctrl.sv
// Galaxian ROM download controller.
// Steers the HPS ioctl byte stream into the CPU, GFX and PROM ROM regions,
// counts in-range bytes, and holds the game core in reset until a complete
// load has settled.
// clk_sys : system clock, all logic on the rising edge.
// reset   : asynchronous active-high reset.
// dl      : download bus (slave side): ioctl stream in, ROM write port and status out.
// SETTLE_CYCLES  : cycles core reset is held after the download ends (16-bit counter).
// EXPECTED_BYTES : minimum in-range byte count for a load to be accepted.
module galaxian_dl_ctrl
   import galaxian_dl_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES  = 16,
   parameter int unsigned EXPECTED_BYTES = 20512
) (
   input  logic                clk_sys,
   input  logic                reset,
   galaxian_dl_ctrl_if.slave   dl
);

   localparam logic [15:0] SETTLE_INIT = 16'(SETTLE_CYCLES);

   state_t             state;
   logic               dl_hist;
   logic [15:0]        settle_cnt;

   region_t            region;
   logic [ROM_AW-1:0]  offset;
   logic               in_range;

   logic               dl_rise;
   logic               dl_fall;
   logic               wr_accept;
   logic               count_ok;

   dl_region_decode u_decode (
      .addr     (dl.ioctl_addr),
      .region   (region),
      .offset   (offset),
      .in_range (in_range)
   );

   // Edges against the registered copy; these only feed registers.
   assign dl_rise = dl.ioctl_download & ~dl_hist;
   assign dl_fall = ~dl.ioctl_download & dl_hist;

   // A strobe on the falling cycle of ioctl_download is dropped by the download term.
   assign wr_accept = (state == StLoad) && dl.ioctl_wr && dl.ioctl_download && in_range;

   assign count_ok = (32'(dl.byte_count) >= EXPECTED_BYTES);

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state         <= StIdle;
         dl_hist       <= 1'b0;
         settle_cnt    <= '0;
         dl.rom_addr   <= '0;
         dl.rom_data   <= '0;
         dl.we_cpu     <= 1'b0;
         dl.we_gfx     <= 1'b0;
         dl.we_prom    <= 1'b0;
         dl.core_reset <= 1'b1;
         dl.dl_done    <= 1'b0;
         dl.dl_error   <= 1'b0;
         dl.byte_count <= '0;
      end else begin
         dl_hist    <= dl.ioctl_download;
         dl.we_cpu  <= 1'b0;
         dl.we_gfx  <= 1'b0;
         dl.we_prom <= 1'b0;

         if (dl_rise) begin
            // A new download restarts from any state, including mid-settle.
            state         <= StLoad;
            dl.byte_count <= '0;
            dl.dl_done    <= 1'b0;
            dl.dl_error   <= 1'b0;
            dl.core_reset <= 1'b1;
         end else begin
            unique case (state)
               StLoad: begin
                  if (wr_accept) begin
                     dl.we_cpu   <= region[RGN_CPU];
                     dl.we_gfx   <= region[RGN_GFX];
                     dl.we_prom  <= region[RGN_PROM];
                     dl.rom_addr <= offset;
                     dl.rom_data <= dl.ioctl_dout;
                     if (dl.byte_count != '1) begin
                        dl.byte_count <= dl.byte_count + 16'd1;
                     end
                  end
                  if (dl_fall) begin
                     state      <= StSettle;
                     settle_cnt <= SETTLE_INIT;
                  end
               end
               StSettle: begin
                  if (settle_cnt == '0) begin
                     if (count_ok) begin
                        state         <= StRun;
                        dl.core_reset <= 1'b0;
                        dl.dl_done    <= 1'b1;
                     end else begin
                        state       <= StFail;
                        dl.dl_error <= 1'b1;
                     end
                  end else begin
                     settle_cnt <= settle_cnt - 16'd1;
                  end
               end
               StIdle, StRun, StFail: begin
               end
               default: begin
                  state         <= StIdle;
                  dl.core_reset <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_galaxian_dl_ctrl.sv
// Scoreboard bench for galaxian_dl_ctrl: the driver pushes each expected ROM
// write, a negedge monitor pops and compares whenever a write enable fires.
module tb_galaxian_dl_ctrl;
   import galaxian_dl_pkg::*;

   localparam int unsigned SETTLE   = 16;
   localparam int unsigned EXPECTED = 20512;

   logic clk = 1'b0;
   logic reset;

   galaxian_dl_ctrl_if dl_if ();

   galaxian_dl_ctrl #(
      .SETTLE_CYCLES  (SETTLE),
      .EXPECTED_BYTES (EXPECTED)
   ) dut (
      .clk_sys (clk),
      .reset   (reset),
      .dl      (dl_if)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [2:0]  region;
      logic [13:0] off;
      logic [7:0]  data;
      int          issued;
   } exp_t;

   exp_t sb[$];

   int checks = 0;
   int failures = 0;
   int exp_count = 0;
   int n_cpu = 0;
   int n_gfx = 0;
   int n_prom = 0;
   int fall_cyc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   // Hand-written region map: {prom, gfx, cpu}.
   function automatic logic [2:0] model_region(input logic [24:0] a);
      if (a < 25'h4000) return 3'b001;
      if (a < 25'h5000) return 3'b010;
      if (a < 25'h5020) return 3'b100;
      return 3'b000;
   endfunction

   function automatic logic [13:0] model_off(input logic [24:0] a);
      logic [24:0] d;
      if (a < 25'h4000)      d = a;
      else if (a < 25'h5000) d = a - 25'h4000;
      else                   d = a - 25'h5000;
      return d[13:0];
   endfunction

   function automatic logic [7:0] pattern(input int a);
      logic [31:0] v;
      v = 32'(a);
      return v[7:0] ^ v[15:8] ^ 8'h5A;
   endfunction

   // Monitor: every write enable must match the oldest expected write.
   always @(negedge clk) begin : mon
      logic [2:0] we;
      exp_t e;
      if (reset === 1'b0) begin
         we = {dl_if.we_prom, dl_if.we_gfx, dl_if.we_cpu};
         if (we != 3'b000) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_write: got we=%b rom_addr=0x%0h, required no write",
                        we, dl_if.rom_addr);
            end else begin
               e = sb.pop_front();
               chk("write_enables", 32'(we), 32'(e.region));
               chk("rom_addr", 32'(dl_if.rom_addr), 32'(e.off));
               chk("rom_data", 32'(dl_if.rom_data), 32'(e.data));
               chk("write_latency", 32'(cyc), 32'(e.issued + 1));
               if (we[0]) n_cpu++;
               if (we[1]) n_gfx++;
               if (we[2]) n_prom++;
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         dl_if.ioctl_wr = 1'b0;
      end
   endtask

   task automatic write(input logic [24:0] a, input logic [7:0] d, input bit live);
      exp_t e;
      @(posedge clk);
      #1;
      dl_if.ioctl_wr   = 1'b1;
      dl_if.ioctl_addr = a;
      dl_if.ioctl_dout = d;
      if (live && model_region(a) != 3'b000) begin
         e.region = model_region(a);
         e.off    = model_off(a);
         e.data   = d;
         e.issued = cyc;
         sb.push_back(e);
         if (exp_count < 65535) exp_count++;
      end
   endtask

   task automatic set_dl(input bit v);
      @(posedge clk);
      #1;
      dl_if.ioctl_wr       = 1'b0;
      dl_if.ioctl_download = v;
      fall_cyc             = cyc;
      if (v) exp_count = 0;
   endtask

   task automatic check_status(input string tag, input bit core, input bit done, input bit err);
      @(negedge clk);
      chk({tag, "_core_reset"}, 32'(dl_if.core_reset), 32'(core));
      chk({tag, "_dl_done"}, 32'(dl_if.dl_done), 32'(done));
      chk({tag, "_dl_error"}, 32'(dl_if.dl_error), 32'(err));
      chk({tag, "_byte_count"}, 32'(dl_if.byte_count), 32'(exp_count));
   endtask

   task automatic drained(input string tag);
      repeat (3) @(negedge clk);
      chk({tag, "_pending_writes"}, 32'(sb.size()), 32'd0);
      sb.delete();
   endtask

   // Waits for the settle phase to resolve; returns cycles since the fall was driven.
   task automatic wait_result(input string tag, output int delta);
      bit held;
      bit seen;
      held  = 1'b1;
      seen  = 1'b0;
      delta = -1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (dl_if.dl_done || dl_if.dl_error) begin
            seen  = 1'b1;
            delta = cyc - fall_cyc;
            break;
         end
         if (dl_if.core_reset !== 1'b1) held = 1'b0;
      end
      chk({tag, "_settle_finished"}, 32'(seen), 32'd1);
      chk({tag, "_core_reset_held_in_settle"}, 32'(held), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish by cycle %0d, required finish", cyc);
      $fatal(1, "bench timed out");
   end

   initial begin
      int delta;

      reset                = 1'b1;
      dl_if.ioctl_download = 1'b0;
      dl_if.ioctl_wr       = 1'b0;
      dl_if.ioctl_addr     = '0;
      dl_if.ioctl_dout     = '0;

      // Reset values.
      @(negedge clk);
      chk("rst_core_reset", 32'(dl_if.core_reset), 32'd1);
      chk("rst_we", 32'({dl_if.we_prom, dl_if.we_gfx, dl_if.we_cpu}), 32'd0);
      chk("rst_dl_done", 32'(dl_if.dl_done), 32'd0);
      chk("rst_dl_error", 32'(dl_if.dl_error), 32'd0);
      chk("rst_byte_count", 32'(dl_if.byte_count), 32'd0);
      chk("rst_rom_addr", 32'(dl_if.rom_addr), 32'd0);
      chk("rst_rom_data", 32'(dl_if.rom_data), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      idle(2);
      check_status("idle", 1'b1, 1'b0, 1'b0);

      // Short load: single GFX write, out-of-range writes, dropped write on the fall.
      set_dl(1'b1);
      idle(1);
      write(25'h0004005, 8'hA5, 1'b1);
      write(25'h0005020, 8'h01, 1'b1);
      write(25'h0010000, 8'h02, 1'b1);
      write(25'h0000000, 8'h11, 1'b1);
      write(25'h000501F, 8'h22, 1'b1);
      idle(1);
      check_status("short_mid", 1'b1, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      dl_if.ioctl_download = 1'b0;
      dl_if.ioctl_wr       = 1'b1;
      dl_if.ioctl_addr     = 25'h0000001;
      dl_if.ioctl_dout     = 8'h99;
      fall_cyc             = cyc;
      idle(1);
      wait_result("short", delta);
      check_status("short_fail", 1'b1, 1'b0, 1'b1);
      drained("short");

      // Strobe outside LOAD is ignored.
      write(25'h0000002, 8'h33, 1'b0);
      idle(2);
      check_status("wr_outside_load", 1'b1, 1'b0, 1'b1);

      // Download re-asserted a few cycles into settle.
      set_dl(1'b1);
      idle(1);
      write(25'h0000100, 8'h5A, 1'b1);
      write(25'h0004FFF, 8'h6B, 1'b1);
      write(25'h0003FFF, 8'h7C, 1'b1);
      idle(1);
      set_dl(1'b0);
      idle(5);
      set_dl(1'b1);
      idle(1);
      check_status("resettle", 1'b1, 1'b0, 1'b0);
      write(25'h0005000, 8'h8D, 1'b1);
      idle(30);
      check_status("reload_held", 1'b1, 1'b0, 1'b0);
      drained("resettle");

      // Reset mid-load with download still high.
      write(25'h0000010, 8'h77, 1'b1);
      idle(2);
      drained("pre_reset");
      @(posedge clk);
      #1 reset = 1'b1;
      exp_count = 0;
      @(negedge clk);
      chk("midrst_core_reset", 32'(dl_if.core_reset), 32'd1);
      chk("midrst_we", 32'({dl_if.we_prom, dl_if.we_gfx, dl_if.we_cpu}), 32'd0);
      chk("midrst_byte_count", 32'(dl_if.byte_count), 32'd0);
      chk("midrst_rom_addr", 32'(dl_if.rom_addr), 32'd0);
      chk("midrst_rom_data", 32'(dl_if.rom_data), 32'd0);
      chk("midrst_flags", 32'({dl_if.dl_done, dl_if.dl_error}), 32'd0);
      idle(2);
      @(posedge clk);
      #1 reset = 1'b0;
      idle(1);
      write(25'h0004001, 8'h88, 1'b1);
      idle(1);
      check_status("post_reset", 1'b1, 1'b0, 1'b0);
      set_dl(1'b0);
      wait_result("post_reset", delta);
      check_status("post_reset_fail", 1'b1, 1'b0, 1'b1);
      drained("post_reset");

      // CPU region only: too short.
      set_dl(1'b1);
      idle(1);
      for (int a = 0; a < 16'h4000; a++) write(25'(a), pattern(a), 1'b1);
      idle(1);
      set_dl(1'b0);
      wait_result("cpu_only", delta);
      check_status("cpu_only", 1'b1, 1'b0, 1'b1);
      chk("cpu_only_count", 32'(dl_if.byte_count), 32'd16384);
      drained("cpu_only");

      // Full load.
      n_cpu  = 0;
      n_gfx  = 0;
      n_prom = 0;
      set_dl(1'b1);
      idle(1);
      for (int a = 0; a < 16'h5020; a++) write(25'(a), pattern(a), 1'b1);
      idle(1);
      set_dl(1'b0);
      wait_result("full", delta);
      chk("full_settle_window", 32'((delta >= int'(SETTLE) + 1) && (delta <= int'(SETTLE) + 3)),
          32'd1);
      check_status("full", 1'b0, 1'b1, 1'b0);
      chk("full_count", 32'(dl_if.byte_count), 32'd20512);
      drained("full");
      chk("full_we_cpu_pulses", 32'(n_cpu), 32'd16384);
      chk("full_we_gfx_pulses", 32'(n_gfx), 32'd4096);
      chk("full_we_prom_pulses", 32'(n_prom), 32'd32);

      // Strobe while running is ignored.
      write(25'h0000000, 8'hEE, 1'b0);
      idle(2);
      check_status("run_ignore_wr", 1'b0, 1'b1, 1'b0);
      drained("final");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
